// File: rtl/line_window_buffer.sv
// Line window buffer: stores a raster pixel stream in four rotating line
// buffers and emits one 3x3 window per cycle once three full lines are held.
module line_window_buffer #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
);
    localparam int PTR_W = $clog2(IMG_WIDTH);
    localparam logic [PTR_W-1:0] LAST_COL    = PTR_W'(IMG_WIDTH - 1);
    localparam logic [PTR_W-1:0] LAST_RD_COL = PTR_W'(IMG_WIDTH - 3);

    typedef enum logic {IDLE, RD} state_t;

    state_t           state, state_next;
    logic [7:0]       line_mem [4][IMG_WIDTH];
    logic [PTR_W-1:0] wr_ptr, rd_col;
    logic [1:0]       wr_line, rd_line;
    logic [2:0]       lines_stored;
    logic             wr_en, line_done, pass_done;
    logic [71:0]      window;

    // A fifth line cannot be held, so writes are dropped while all four are full.
    assign wr_en     = i_pixel_data_valid && (lines_stored != 3'd4);
    assign line_done = wr_en && (wr_ptr == LAST_COL);
    assign pass_done = (state == RD) && (rd_col == LAST_RD_COL);

    // NOTE: the line storage has no reset; its contents only matter after being
    // rewritten, and leaving it out lets the arrays map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) line_mem[wr_line][wr_ptr] <= i_pixel_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            wr_line <= '0;
        end else if (wr_en) begin
            if (line_done) begin
                wr_ptr  <= '0;
                wr_line <= wr_line + 2'd1;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Line completion and pass completion on the same edge cancel out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lines_stored <= '0;
        end else begin
            case ({line_done, pass_done})
                2'b10:   lines_stored <= lines_stored + 3'd1;
                2'b01:   lines_stored <= lines_stored - 3'd1;
                default: lines_stored <= lines_stored;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lines_stored >= 3'd3) state_next = RD;
            RD:      if (pass_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_col  <= '0;
            rd_line <= '0;
        end else if (state == RD) begin
            if (pass_done) begin
                rd_col  <= '0;
                rd_line <= rd_line + 2'd1;
            end else begin
                rd_col <= rd_col + PTR_W'(1);
            end
        end
    end

    // Row 0 is the oldest line, col 0 the leftmost pixel; byte k = row*3 + col.
    always_comb begin
        window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window[8*(r*3+c) +: 8] = line_mem[rd_line + 2'(r)][rd_col + PTR_W'(c)];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= (state == RD);
            o_intr             <= pass_done;
            if (state == RD) o_pixel_data <= window;
        end
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer: directed and randomized line
// streams compared against an image-array reference of the 3x3 windows.
module tb_line_window_buffer;
    localparam int W    = 8;
    localparam int MAXL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix;
    logic        pix_valid;
    logic [71:0] win;
    logic        win_valid;
    logic        intr;

    line_window_buffer #(.IMG_WIDTH(W)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pix_valid),
        .o_pixel_data       (win),
        .o_pixel_data_valid (win_valid),
        .o_intr             (intr)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [7:0]  img [MAXL][W];
    int          lines_written = 0;
    int          passes = 0, win_idx = 0, intr_cnt = 0, valid_cnt = 0;
    bit          prev_intr = 1'b0;
    int          line_done_cyc  [MAXL];
    int          pass_start_cyc [MAXL];
    logic [71:0] first_win [MAXL];
    logic [71:0] last_win  [MAXL];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Window for pass p, position x: rows are lines p..p+2, cols x..x+2.
    function automatic logic [71:0] model_window(input int p, input int x);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(r*3+c) +: 8] = img[p+r][x+c];
        return w;
    endfunction

    // Monitor: every output cycle is checked against the image reference.
    always @(negedge clk) begin
        if (rst) begin
            passes = 0; win_idx = 0; intr_cnt = 0; valid_cnt = 0; prev_intr = 1'b0;
        end else begin
            if (prev_intr) check("gap_after_pass", 72'(win_valid), 72'd0);
            if (win_valid) begin
                valid_cnt++;
                check("window_expected", 72'(passes + 2 < lines_written), 72'd1);
                if (passes + 2 < lines_written)
                    check("window", win, model_window(passes, win_idx));
                check("intr_on_last", 72'(intr), 72'(win_idx == W - 3));
                if (win_idx == 0 && passes < MAXL) begin
                    pass_start_cyc[passes] = cyc;
                    first_win[passes]      = win;
                end
                if (win_idx == W - 3) begin
                    if (passes < MAXL) last_win[passes] = win;
                    passes++;
                    win_idx = 0;
                end else begin
                    win_idx++;
                end
            end else begin
                check("intr_without_valid", 72'(intr), 72'd0);
            end
            if (intr) intr_cnt++;
            prev_intr = intr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input int max_gap, input bit rnd);
        int ln;
        ln = lines_written;
        for (int x = 0; x < W; x++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            img[ln][x] = rnd ? 8'($urandom) : 8'(((ln % 16) << 4) | x);
            pix        = img[ln][x];
            pix_valid  = 1'b1;
            tick();
            pix_valid  = 1'b0;
        end
        line_done_cyc[ln] = cyc;
        lines_written     = ln + 1;
    endtask

    task automatic reset_check(input string tag);
        rst       = 1'b1;
        pix_valid = 1'b0;
        #1;
        check({tag, "_data"},  win, 72'd0);
        check({tag, "_valid"}, 72'(win_valid), 72'd0);
        check({tag, "_intr"},  72'(intr), 72'd0);
        lines_written = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_passes(input int n, input int budget);
        int k;
        k = 0;
        while (passes < n && k < budget) begin
            tick();
            k++;
        end
        repeat (3 * W) tick();
        check("pass_count", 72'(passes), 72'(n));
        check("intr_count", 72'(intr_cnt), 72'(n));
    endtask

    initial begin
        int k;
        rst = 1'b1; pix = '0; pix_valid = 1'b0;
        #12;
        check("reset_data",  win, 72'd0);
        check("reset_valid", 72'(win_valid), 72'd0);
        check("reset_intr",  72'(intr), 72'd0);
        tick();
        rst = 1'b0;
        tick();

        // Three lines, counter-pattern pixels: one pass with known windows.
        for (int l = 0; l < 3; l++) write_line(0, 1'b0);
        wait_passes(1, 40);
        check("latency_pass1", 72'(pass_start_cyc[0]), 72'(line_done_cyc[2] + 2));
        check("first_window",  first_win[0], 72'h222120121110020100);
        check("last_window",   last_win[0],  72'h272625171615070605);

        // Reset while idle with a held window on the output.
        reset_check("rst_idle");

        // Four lines back to back: line 3 is written during pass 1.
        for (int l = 0; l < 4; l++) write_line(0, 1'b0);
        wait_passes(2, 60);
        check("pass2_first_window", first_win[1], 72'h323130222120121110);
        check("latency_pass2", 72'(pass_start_cyc[1]), 72'(line_done_cyc[3] + 2));

        // Start a third pass, then reset in the middle of it.
        write_line(0, 1'b0);
        k = 0;
        while (!win_valid && k < 20) begin
            tick();
            k++;
        end
        tick();
        #3;
        check("midpass_valid_seen", 72'(win_valid), 72'd1);
        reset_check("rst_midpass");

        // Two fresh lines are not enough for a window.
        write_line(0, 1'b0);
        write_line(0, 1'b0);
        repeat (30) tick();
        check("no_valid_two_lines", 72'(valid_cnt), 72'd0);
        check("no_intr_two_lines",  72'(intr_cnt), 72'd0);
        write_line(0, 1'b0);
        wait_passes(1, 40);

        // Seven random lines with random input gaps: five passes, index wraps.
        reset_check("rst_pre_random");
        for (int l = 0; l < 7; l++) write_line(3, 1'b1);
        wait_passes(5, 300);

        // Continuous six-line stream: line completion lands next to pass ends.
        reset_check("rst_pre_stream");
        for (int l = 0; l < 6; l++) write_line(0, 1'b1);
        wait_passes(4, 100);
        check("stream_valid_total", 72'(valid_cnt), 72'(4 * (W - 2)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
